// File: rtl/lagrange_coeff_eval_pkg.sv
// Shared field-arithmetic definitions for the sumcheck datapath: field width,
// modulus, modular adder and the common handshake FSM state type.
`ifndef LAGRANGE_COEFF_EVAL_PKG_SV
`define LAGRANGE_COEFF_EVAL_PKG_SV

package lagrange_coeff_eval_pkg;

    localparam int F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_Q = 16'd65521;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MUL,
        ST_ADD
    } hs_state_t;

    // Both operands must already be reduced, so one conditional subtract suffices.
    function automatic logic [F_NBITS-1:0] modadd(input logic [F_NBITS-1:0] a,
                                                  input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q})
            s = s - {1'b0, F_Q};
        return F_NBITS'(s);
    endfunction

endpackage

`endif

// File: rtl/lagrange_coeff_eval_field_multiplier.sv
// Iterative modular multiplier: one bit of b per cycle, MSB first, so the result
// is ready F_NBITS+1 cycles after the cycle en is sampled.
`ifndef ALWAYS_FF
`define ALWAYS_FF always_ff
`endif
`ifndef ALWAYS_COMB
`define ALWAYS_COMB always_comb
`endif

module field_multiplier
    import lagrange_coeff_eval_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] out,
    output logic               ready
);

    localparam int CNT_W = $clog2(F_NBITS + 1);

    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic [F_NBITS-1:0] a_reg;
    logic [F_NBITS-1:0] b_reg;
    logic [F_NBITS-1:0] step;

    // Double-and-add: r = 2r (+ a when the current bit of b is set), all mod F_Q.
    `ALWAYS_COMB begin
        step = modadd(out, out);
        if (b_reg[F_NBITS-1])
            step = modadd(step, a_reg);
    end

    `ALWAYS_FF @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy  <= 1'b0;
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            out   <= '0;
        end else if (busy) begin
            out   <= step;
            b_reg <= b_reg << 1;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                busy <= 1'b0;
        end else if (en) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(F_NBITS);
            a_reg <= a;
            b_reg <= b;
            out   <= '0;
        end
    end

    assign ready = ~busy;

endmodule

// File: rtl/lagrange_coeff_eval.sv
// Captures npoints coefficients and evaluates p(tau) by Horner's rule using one
// shared multi-cycle field multiplier and an inline modular adder.
`ifndef ALWAYS_FF
`define ALWAYS_FF always_ff
`endif
`ifndef ALWAYS_COMB
`define ALWAYS_COMB always_comb
`endif

module lagrange_coeff_eval
    import lagrange_coeff_eval_pkg::*;
#(
    parameter int npoints = 3
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               c_wren,
    input  logic [F_NBITS-1:0] c_data,
    input  logic [F_NBITS-1:0] tau,
    input  logic               en,
    output logic [F_NBITS-1:0] eval_out,
    output logic               full,
    output logic               ovf,
    output logic               ready,
    output logic               ready_pulse
);

    localparam int CW = $clog2(npoints + 1);
    localparam logic [CW-1:0] NP    = CW'(npoints);
    localparam logic [CW-1:0] LAST  = CW'(npoints - 1);
    localparam logic [CW-1:0] K_TOP = CW'((npoints >= 2) ? npoints - 2 : 0);

    hs_state_t          state, state_nxt;
    logic [F_NBITS-1:0] acc, acc_nxt;
    logic [F_NBITS-1:0] tau_reg, tau_nxt;
    logic [F_NBITS-1:0] eval_nxt;
    logic [CW-1:0]      k, k_nxt;
    logic [CW-1:0]      wcnt, wcnt_nxt, wr_idx;
    logic               mul_en_reg, mul_en_nxt;
    logic               en_dly, ready_dly;
    logic               start, evaluating, done, wr_ok, enter_mul;
    logic [F_NBITS-1:0] coeff [2**CW];
    logic [F_NBITS-1:0] mul_out;
    logic               mul_ready;

    field_multiplier u_field_multiplier (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mul_en_reg),
        .a     (acc),
        .b     (tau_reg),
        .out   (mul_out),
        .ready (mul_ready)
    );

    assign start       = en & ~en_dly;
    assign ready       = ~start & (state == ST_IDLE);
    assign ready_pulse = ready & ~ready_dly;
    assign full        = (wcnt == NP);
    assign evaluating  = (state == ST_MUL) || (state == ST_ADD);
    assign done        = (state == ST_ADD) && (k == '0);
    // The completion cycle frees the buffer, so a write there opens the next batch.
    assign wr_ok       = c_wren & ((~full & ~evaluating) | done);
    assign wr_idx      = done ? '0 : wcnt;

    `ALWAYS_COMB begin
        state_nxt  = state;
        acc_nxt    = acc;
        k_nxt      = k;
        tau_nxt    = tau_reg;
        eval_nxt   = eval_out;
        wcnt_nxt   = wcnt;
        mul_en_nxt = 1'b0;
        enter_mul  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    tau_nxt = tau;
                    if (full)
                        enter_mul = 1'b1;
                    else
                        state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (full)
                    enter_mul = 1'b1;
            end
            ST_MUL: begin
                if (~mul_en_reg & mul_ready)
                    state_nxt = ST_ADD;
            end
            ST_ADD: begin
                acc_nxt = modadd(mul_out, coeff[k]);
                if (k == '0) begin
                    eval_nxt  = acc_nxt;
                    wcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    k_nxt      = k - CW'(1);
                    mul_en_nxt = 1'b1;
                    state_nxt  = ST_MUL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A constant polynomial needs no multiply rounds at all.
        if (enter_mul) begin
            if (npoints == 1) begin
                eval_nxt  = coeff[0];
                wcnt_nxt  = '0;
                state_nxt = ST_IDLE;
            end else begin
                acc_nxt    = coeff[LAST];
                k_nxt      = K_TOP;
                mul_en_nxt = 1'b1;
                state_nxt  = ST_MUL;
            end
        end
        if (wr_ok)
            wcnt_nxt = wcnt_nxt + CW'(1);
    end

    `ALWAYS_FF @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            acc        <= '0;
            k          <= '0;
            tau_reg    <= '0;
            eval_out   <= '0;
            wcnt       <= '0;
            ovf        <= 1'b0;
            mul_en_reg <= 1'b0;
            en_dly     <= 1'b1;
            ready_dly  <= 1'b1;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            k          <= k_nxt;
            tau_reg    <= tau_nxt;
            eval_out   <= eval_nxt;
            wcnt       <= wcnt_nxt;
            ovf        <= ovf | (c_wren & ~wr_ok);
            mul_en_reg <= mul_en_nxt;
            en_dly     <= en;
            ready_dly  <= ready;
        end
    end

    `ALWAYS_FF @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 2**CW; i++)
                coeff[i] <= '0;
        end else if (wr_ok) begin
            coeff[wr_idx] <= c_data;
        end
    end

endmodule
